apb_gpio_irq: RTL
=================

Name: apb_gpio_irq

Overview:
Parametrised APB3 GPIO slave, successor to the 8-bit two-register GPIO.
- Configurable pin count and optional wait states.
- Per-pin direction, atomic set/clear of the output register.
- Input synchronizer, and rising/falling edge interrupts with W1C status and a single IRQ line.
- Sits on the peripheral APB bus next to the other slaves.

Parameters:
GPIO_W, 8, number of pins (1..32); register bits above GPIO_W read 0 and ignore writes
ADDR_W, 12, APB address width; decode uses PADDR[4:2]; PADDR[1:0] ignored
SYNC_STAGES, 2, flops in the input synchronizer (>=2)
WAIT_STATES, 0, extra access-phase cycles before PREADY rises (0..7)

Ports:
PCLK  in  1  APB clock, single clock domain
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PADDR  in  ADDR_W  byte address
PWRITE  in  1  1=write
PSTRB  in  4  byte-lane write strobes
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error on unmapped offset or write to read-only register
GPIO_DATA_IN  in  GPIO_W  asynchronous pin inputs
GPIO_DATA_OUT  out  GPIO_W  DATA_OUT & DIR; non-output pins drive 0
GPIO_DIR  out  GPIO_W  output enable per pin, 1=output
IRQ  out  1  registered OR of IRQ_STATUS

Behaviour:
- Register map (offset, access):
  - 0x00 DIR, RW.
  - 0x04 DATA_OUT, RW.
  - 0x08 DATA_IN, RO: synchronized pin value, for all pins regardless of direction.
  - 0x0C RISE_EN, RW.
  - 0x10 FALL_EN, RW.
  - 0x14 IRQ_STATUS, read / W1C.
  - 0x18 OUT_SET, WO: DATA_OUT |= wdata.
  - 0x1C OUT_CLR, WO: DATA_OUT &= ~wdata. OUT_SET and OUT_CLR read 0.
- Byte lanes: only lanes with PSTRB[k]=1 update bits [8k+7:8k]. This applies to RW, W1C, SET and CLR alike.
- FSM: IDLE -> SETUP on PSEL&!PENABLE. SETUP -> ACCESS on PENABLE.
- ACCESS holds while wait_cnt<WAIT_STATES; wait_cnt is a counter cleared on SETUP entry.
  - PREADY=1 only in ACCESS with wait_cnt==WAIT_STATES.
  - Then -> SETUP if PSEL&!PENABLE, else IDLE.
  - With WAIT_STATES=0, PREADY rises in the first access cycle.
- Write commit: registers update at the PCLK edge where PSEL&PENABLE&PREADY&PWRITE.
- Read data: PRDATA is a registered value and is valid while PREADY=1; it is 0 otherwise.
- PSLVERR: asserted with PREADY for:
  - PADDR[ADDR_W-1:5] != 0;
  - a write to DATA_IN.
  Erroring writes change no state. Erroring reads return 0.
- Synchronizer: GPIO_DATA_IN passes through SYNC_STAGES flops, giving sync. A prev register holds sync delayed 1 cycle.
- Edge events:
  - rise = sync&~prev&~DIR&RISE_EN.
  - fall = ~sync&prev&~DIR&FALL_EN.
  - Event bits OR into IRQ_STATUS each cycle.
- Pin-change latency: pin change -> IRQ_STATUS bit set after SYNC_STAGES+1 edges -> IRQ after one more edge.
- Same-cycle W1C and new event on one bit: the set wins and the bit stays 1.
- OUT_SET and OUT_CLR are separate offsets, so they never collide.
- Changing DIR or enables does not retroactively set or clear status. Clearing RISE_EN/FALL_EN does not clear pending status.
- Reset (asynchronous, PRESETn=0): all registers, synchronizer, prev and wait_cnt go to 0; FSM -> IDLE; PRDATA, PREADY, PSLVERR, IRQ, GPIO_DATA_OUT and GPIO_DIR are 0.
  - prev resets to 0, so an input held high at reset release can produce one rise event if RISE_EN is later set before the synchronizer fills. This is acceptable, because RISE_EN=0 out of reset.
- Reset mid-transfer: the transfer is aborted with no commit. The master must restart from SETUP.
- PSEL dropped in ACCESS: FSM -> IDLE with no commit.

Decomposition:
- Package apb_gpio_pkg:
  - register offset localparams (OFS_DIR .. OFS_CLR);
  - FSM state enum (IDLE, SETUP, ACCESS);
  - the PSTRB-to-bit-mask expansion function.
- One sub-module, gpio_sync_edge, parametrised by GPIO_W and SYNC_STAGES. Outputs: sync, rise_raw, fall_raw.
- Enable masking, status and the APB logic stay in apb_gpio_irq.

Test Plan:
- Reset, GPIO_W=8, WAIT_STATES=0: write DIR=0x0F, DATA_OUT=0xA5 with PSTRB=0001 -> GPIO_DATA_OUT=0x05, GPIO_DIR=0x0F. Read 0x04 -> 0x000000A5, PREADY in the first access cycle.
- OUT_SET=0xF0 then OUT_CLR=0x81, with DIR=0xFF -> DATA_OUT read 0x74 and pins show 0x74. Write with PSTRB=0010 to DATA_OUT -> no change.
- DIR=0x00, RISE_EN=0x01, FALL_EN=0x80; drive GPIO_DATA_IN 0x80->0x01 -> IRQ_STATUS=0x81 after 3 edges, IRQ=1 one edge later. W1C 0x01 -> status 0x80, IRQ stays 1. W1C 0x80 -> IRQ=0.
- W1C of bit0 in the same cycle as a new rise on pin0 -> bit0 remains 1.
- WAIT_STATES=3: read DATA_IN -> PREADY low for 3 access cycles, high on the 4th with the synchronized value. Access to 0x20 -> PSLVERR=1, PRDATA=0, no state change. Write to 0x08 -> PSLVERR=1.
- Assert PRESETn=0 mid-ACCESS of a DATA_OUT write -> all outputs 0 immediately, and the write is not committed after release.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO slave: register offsets, bus FSM states
// and the byte-strobe expansion helper.
package apb_gpio_pkg;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] OFS_DIR        = 3'd0;
  localparam logic [2:0] OFS_DATA_OUT   = 3'd1;
  localparam logic [2:0] OFS_DATA_IN    = 3'd2;
  localparam logic [2:0] OFS_RISE_EN    = 3'd3;
  localparam logic [2:0] OFS_FALL_EN    = 3'd4;
  localparam logic [2:0] OFS_IRQ_STATUS = 3'd5;
  localparam logic [2:0] OFS_SET        = 3'd6;
  localparam logic [2:0] OFS_CLR        = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Expand PSTRB into a 32-bit mask, one byte per strobe bit
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (strb[k]) m[8*k +: 8] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchronizer plus one-cycle history for raw edge detection.
module gpio_sync_edge #(
  parameter int unsigned GPIO_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] din,
  output logic [GPIO_W-1:0] sync,
  output logic [GPIO_W-1:0] rise_raw,
  output logic [GPIO_W-1:0] fall_raw
);

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] pipe;
  logic [GPIO_W-1:0]                  prev;

  // Shift pins through the synchronizer chain and keep the previous synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
      prev <= '0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-2:0], din};
      prev <= pipe[SYNC_STAGES-1];
    end
  end

  assign sync     = pipe[SYNC_STAGES-1];
  assign rise_raw = sync & ~prev;
  assign fall_raw = ~sync & prev;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: direction, output data with atomic set/clear, synchronized
// inputs and W1C edge interrupt status with a single registered IRQ line.
module apb_gpio_irq
  import apb_gpio_pkg::*;
#(
  parameter int unsigned GPIO_W      = 8,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [3:0]        PSTRB,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] GPIO_DATA_IN,
  output logic [GPIO_W-1:0] GPIO_DATA_OUT,
  output logic [GPIO_W-1:0] GPIO_DIR,
  output logic              IRQ
);

  localparam logic [2:0] WAIT_MAX = 3'(WAIT_STATES);

  apb_state_e        state_q, state;
  logic [2:0]        wait_cnt;
  logic              done_q;
  logic              ready;
  logic              err;
  logic              commit;
  logic [2:0]        ofs;
  logic [31:0]       mask32;
  logic [GPIO_W-1:0] wm;
  logic [GPIO_W-1:0] w1c_mask;
  logic [GPIO_W-1:0] events;
  logic [31:0]       rd_val;
  logic [31:0]       prdata_q;
  logic              irq_q;

  logic [GPIO_W-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q;
  logic [GPIO_W-1:0] sync, rise_raw, fall_raw;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA, mask32};

  gpio_sync_edge #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .din      (GPIO_DATA_IN),
    .sync     (sync),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  // state_q holds the previous cycle's phase; state classifies the current
  // cycle from it and the live bus so PREADY can rise in the first access cycle
  always_comb begin
    state = IDLE;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state = SETUP;
      end
      SETUP: begin
        if (PSEL && PENABLE)  state = ACCESS;
        else if (PSEL)        state = SETUP;
      end
      ACCESS: begin
        if (PSEL && !PENABLE)                  state = SETUP;
        else if (!done_q && PSEL && PENABLE)   state = ACCESS;
      end
      default: state = IDLE;
    endcase
  end

  // Bus phase register, wait-state counter and completion flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state;
      done_q  <= ready;
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 3'd1;
    end
  end

  assign ready    = (state == ACCESS) && (wait_cnt == WAIT_MAX);
  assign ofs      = PADDR[4:2];
  assign err      = (|PADDR[ADDR_W-1:5]) || (PWRITE && ofs == OFS_DATA_IN);
  assign commit   = PSEL && PENABLE && ready && PWRITE && !err;
  assign mask32   = strb_to_mask(PSTRB);
  assign wm       = PWDATA[GPIO_W-1:0] & mask32[GPIO_W-1:0];
  assign w1c_mask = (commit && ofs == OFS_IRQ_STATUS) ? wm : '0;
  assign events   = (rise_raw & ~dir_q & rise_en_q) | (fall_raw & ~dir_q & fall_en_q);

  // Read mux, zero-extended above GPIO_W
  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_DIR:        rd_val[GPIO_W-1:0] = dir_q;
      OFS_DATA_OUT:   rd_val[GPIO_W-1:0] = out_q;
      OFS_DATA_IN:    rd_val[GPIO_W-1:0] = sync;
      OFS_RISE_EN:    rd_val[GPIO_W-1:0] = rise_en_q;
      OFS_FALL_EN:    rd_val[GPIO_W-1:0] = fall_en_q;
      OFS_IRQ_STATUS: rd_val[GPIO_W-1:0] = status_q;
      default:        rd_val = '0;
    endcase
  end

  // Control registers, byte-lane masked; SET/CLR modify DATA_OUT in place
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (commit) begin
      case (ofs)
        OFS_DIR:      dir_q     <= (dir_q     & ~mask32[GPIO_W-1:0]) | wm;
        OFS_DATA_OUT: out_q     <= (out_q     & ~mask32[GPIO_W-1:0]) | wm;
        OFS_RISE_EN:  rise_en_q <= (rise_en_q & ~mask32[GPIO_W-1:0]) | wm;
        OFS_FALL_EN:  fall_en_q <= (fall_en_q & ~mask32[GPIO_W-1:0]) | wm;
        OFS_SET:      out_q     <= out_q | wm;
        OFS_CLR:      out_q     <= out_q & ~wm;
        default:      ;
      endcase
    end
  end

  // Interrupt status: new events win over a same-cycle W1C; IRQ lags one cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | events;
      irq_q    <= |status_q;
    end
  end

  // Read data captured ahead of the ready cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) prdata_q <= '0;
    else          prdata_q <= (PSEL && !PWRITE && !err) ? rd_val : '0;
  end

  assign PREADY        = ready;
  assign PSLVERR       = ready && err;
  assign PRDATA        = ready ? prdata_q : '0;
  assign IRQ           = irq_q;
  assign GPIO_DIR      = dir_q;
  assign GPIO_DATA_OUT = out_q & dir_q;

endmodule
